// File: rtl/InstructionSetPkg.sv
// Shared ISA definitions for the CPU datapath: operand widths,
// ALU operation codes and the packed status-flag word.
package InstructionSetPkg;

  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 6;

  typedef enum logic [3:0] {
    MOVE = 4'd0,
    NAND = 4'd1,
    NOR  = 4'd2,
    ROL  = 4'd3,
    ROR  = 4'd4,
    LIL  = 4'd5,
    LIU  = 4'd6,
    ADC  = 4'd7,
    SUB  = 4'd8,
    DIV  = 4'd9,
    MOD  = 4'd10,
    MUL  = 4'd11,
    MUH  = 4'd12
  } eOperation;

  typedef struct packed {
    logic Overflow;
    logic Parity;
    logic Negative;
    logic Zero;
    logic Carry;
  } sFlags;

endpackage

// File: rtl/alu_flag_gen.sv
// Result-derived status flags for the ALU.
// Ports: Result (in, 16) -> Zero, Negative, Parity (even count of ones).
module alu_flag_gen
  import InstructionSetPkg::*;
(
  input  logic [DataWidth-1:0] Result,
  output logic                 Zero,
  output logic                 Negative,
  output logic                 Parity
);

  assign Zero     = (Result == '0);
  assign Negative = Result[DataWidth-1];
  assign Parity   = ~^Result;

endmodule

// File: rtl/arithmetic_logic_unit.sv
// 13-operation 16-bit ALU producing a result and a 5-bit flag word.
// Ports: Clock, Reset (sync, active-high), Operation, InFlags, InImm,
// InSrc, InDest -> OutDest, OutFlags.
// ALU_OUTPUT_REG_EN: when defined, outputs are registered (1-cycle
// latency) and Reset clears them; otherwise purely combinational.
module arithmetic_logic_unit
  import InstructionSetPkg::*;
(
  input  logic                              Clock,
  input  logic                              Reset,
  input  eOperation                         Operation,
  input  sFlags                             InFlags,
  input  logic signed [ImmediateWidth-1:0]  InImm,
  input  logic signed [DataWidth-1:0]       InSrc,
  input  logic signed [DataWidth-1:0]       InDest,
  output logic signed [DataWidth-1:0]       OutDest,
  output sFlags                             OutFlags
);

  logic                 cin;
  logic [DataWidth:0]   adc_sum;
  logic [DataWidth:0]   sub_diff;
  logic                 div_zero;
  logic signed [16:0]   dvd;
  logic signed [16:0]   dvs;
  logic signed [16:0]   quo;
  logic signed [16:0]   rem;
  logic signed [31:0]   mcand;
  logic signed [31:0]   mplier;
  logic signed [31:0]   prod;

  logic [DataWidth-1:0] result_d;
  sFlags                flags_d;
  logic                 carry_d;
  logic                 ovf_d;
  logic                 upd_d;
  logic                 zero_w;
  logic                 neg_w;
  logic                 par_w;

  assign cin = InFlags.Carry;

  assign adc_sum  = {1'b0, InDest} + {1'b0, InSrc}
                  + {{DataWidth{1'b0}}, cin};
  // Bit 16 of the 17-bit difference is the borrow.
  assign sub_diff = {1'b0, InDest} - {1'b0, InSrc}
                  - {{DataWidth{1'b0}}, cin};

  // Divide in 17 bits so -32768 / -1 stays defined; the divisor is
  // forced to 1 on zero so no X reaches the result mux.
  assign div_zero = (InSrc == '0);
  assign dvd      = {InDest[15], InDest};
  assign dvs      = div_zero ? 17'sd1 : {InSrc[15], InSrc};
  assign quo      = dvd / dvs;
  assign rem      = dvd % dvs;

  assign mcand  = {{16{InDest[15]}}, InDest};
  assign mplier = {{16{InSrc[15]}}, InSrc};
  assign prod   = mcand * mplier;

  logic unused_div;
  assign unused_div = ^{quo[16], rem[16]};

  always_comb begin
    result_d = InDest;
    carry_d  = InFlags.Carry;
    ovf_d    = InFlags.Overflow;
    upd_d    = 1'b1;
    unique case (Operation)
      MOVE: result_d = InSrc;
      NAND: result_d = ~(InDest & InSrc);
      NOR:  result_d = ~(InDest | InSrc);
      ROL: begin
        result_d = {InSrc[14:0], cin};
        carry_d  = InSrc[15];
      end
      ROR: begin
        result_d = {cin, InSrc[15:1]};
        carry_d  = InSrc[0];
      end
      LIL: result_d = {{10{InImm[5]}}, InImm};
      LIU: begin
        if (InImm[5])
          result_d = {InImm[4:0], InDest[10:0]};
        else
          result_d = {{5{InImm[4]}}, InImm[4:0],
                      InDest[5:0]};
      end
      ADC: begin
        result_d = adc_sum[15:0];
        carry_d  = adc_sum[16];
        ovf_d    = (InDest[15] == InSrc[15])
                && (adc_sum[15] != InDest[15]);
      end
      SUB: begin
        result_d = sub_diff[15:0];
        carry_d  = sub_diff[16];
        ovf_d    = (InDest[15] != InSrc[15])
                && (sub_diff[15] != InDest[15]);
      end
      DIV: begin
        result_d = div_zero ? 16'hFFFF : quo[15:0];
        if (div_zero) ovf_d = 1'b1;
      end
      MOD: begin
        result_d = div_zero ? InDest : rem[15:0];
        if (div_zero) ovf_d = 1'b1;
      end
      MUL: result_d = prod[15:0];
      MUH: result_d = prod[31:16];
      default: upd_d = 1'b0;
    endcase
  end

  alu_flag_gen u_flag_gen (
    .Result   (result_d),
    .Zero     (zero_w),
    .Negative (neg_w),
    .Parity   (par_w)
  );

  always_comb begin
    flags_d = InFlags;
    if (upd_d) begin
      flags_d.Overflow = ovf_d;
      flags_d.Parity   = par_w;
      flags_d.Negative = neg_w;
      flags_d.Zero     = zero_w;
      flags_d.Carry    = carry_d;
    end
  end

`ifdef ALU_OUTPUT_REG_EN
  logic [DataWidth-1:0] dest_q;
  sFlags                flags_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dest_q  <= '0;
      flags_q <= '0;
    end else begin
      dest_q  <= result_d;
      flags_q <= flags_d;
    end
  end

  assign OutDest  = dest_q;
  assign OutFlags = flags_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ Reset;

  assign OutDest  = result_d;
  assign OutFlags = flags_d;
`endif

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Self-checking bench for arithmetic_logic_unit: directed table,
// randomized model comparison and latency/reset sequences.
module tb_arithmetic_logic_unit;
  import InstructionSetPkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  eOperation          op;
  sFlags              fl;
  logic [5:0]         imm;
  logic [15:0]        src;
  logic [15:0]        dst;
  logic signed [15:0] out_d;
  sFlags              out_f;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arithmetic_logic_unit dut (
    .Clock     (clk),
    .Reset     (rst),
    .Operation (op),
    .InFlags   (fl),
    .InImm     (imm),
    .InSrc     (src),
    .InDest    (dst),
    .OutDest   (out_d),
    .OutFlags  (out_f)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  fin;
    logic [5:0]  imm;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] res;
    logic [4:0]  fl;
    logic [4:0]  mask;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_f(string nm, logic [4:0] act,
                       logic [4:0] exp, logic [4:0] mask);
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s flags: got %b expected %b (mask %b)",
               nm, act, exp, mask);
    end
  endtask

  task automatic drive(logic [3:0] o, logic [4:0] f,
                       logic [5:0] i, logic [15:0] s,
                       logic [15:0] d);
    op  = eOperation'(o);
    fl  = sFlags'(f);
    imm = i;
    src = s;
    dst = d;
  endtask

  // Reference built from the arithmetic meaning of each operation.
  function automatic void model(
    input  logic [3:0]  o,
    input  logic [4:0]  fin,
    input  logic [5:0]  i,
    input  logic [15:0] s,
    input  logic [15:0] d,
    output logic [15:0] r,
    output logic [4:0]  f);
    int     sd, ss, ud, us, c, t, st, s5, si;
    longint p;
    logic   cy, v, upd;
    sd = $signed(d);
    ss = $signed(s);
    ud = d;
    us = s;
    c  = fin[0];
    cy = fin[0];
    v  = fin[4];
    upd = 1'b1;
    r = d;
    case (o)
      4'd0: r = s;
      4'd1: r = ~(d & s);
      4'd2: r = ~(d | s);
      4'd3: begin
        t = us * 2 + c; r = t[15:0]; cy = (us >= 32768);
      end
      4'd4: begin
        t = us / 2 + c * 32768; r = t[15:0]; cy = (us % 2 == 1);
      end
      4'd5: begin
        si = $signed(i); r = si[15:0];
      end
      4'd6: begin
        if (i[5]) begin
          t = int'(i[4:0]) * 2048 + ud % 2048;
        end else begin
          s5 = $signed(i[4:0]);
          t = s5 * 64 + ud % 64;
        end
        r = t[15:0];
      end
      4'd7: begin
        t = ud + us + c; r = t[15:0]; cy = (t > 65535);
        st = sd + ss + c; v = (st > 32767) || (st < -32768);
      end
      4'd8: begin
        st = sd - ss - c; r = st[15:0];
        cy = (ud < us + c);
        v = (st > 32767) || (st < -32768);
      end
      4'd9: begin
        if (ss == 0) begin r = 16'hFFFF; v = 1'b1; end
        else begin st = sd / ss; r = st[15:0]; end
      end
      4'd10: begin
        if (ss == 0) begin r = d; v = 1'b1; end
        else begin st = sd % ss; r = st[15:0]; end
      end
      4'd11: begin p = longint'(sd) * ss; r = p[15:0]; end
      4'd12: begin p = longint'(sd) * ss; r = p[31:16]; end
      default: upd = 1'b0;
    endcase
    if (upd)
      f = {v, ($countones(r) % 2 == 0), r[15], (r == 16'h0), cy};
    else
      f = fin;
  endfunction

  logic [15:0] er, er2;
  logic [4:0]  ef, ef2;

  initial begin
    tbl.push_back('{4'd0, 5'h00, 6'h00, 16'h7AD9, 16'h0000, 16'h7AD9, 5'h00, 5'h00});
    tbl.push_back('{4'd1, 5'h00, 6'h00, 16'hA5A5, 16'h9999, 16'h7E7E, 5'h00, 5'h00});
    tbl.push_back('{4'd2, 5'h00, 6'h00, 16'hA5A5, 16'h9999, 16'h4242, 5'h00, 5'h00});
    tbl.push_back('{4'd3, 5'h01, 6'h00, 16'h5555, 16'h0000, 16'hAAAB, 5'h00, 5'h01});
    tbl.push_back('{4'd4, 5'h01, 6'h00, 16'h5555, 16'h0000, 16'hAAAA, 5'h01, 5'h01});
    tbl.push_back('{4'd4, 5'h01, 6'h00, 16'h0000, 16'h0000, 16'h8000, 5'h00, 5'h01});
    tbl.push_back('{4'd5, 5'h00, 6'h26, 16'h0000, 16'h0000, 16'hFFE6, 5'h00, 5'h00});
    tbl.push_back('{4'd6, 5'h00, 6'h3F, 16'h0000, 16'h0000, 16'hF800, 5'h00, 5'h00});
    tbl.push_back('{4'd6, 5'h00, 6'h0F, 16'h0000, 16'hAAAA, 16'h03EA, 5'h00, 5'h00});
    tbl.push_back('{4'd6, 5'h00, 6'h3F, 16'h0000, 16'hAAAA, 16'hFAAA, 5'h00, 5'h00});
    tbl.push_back('{4'd7, 5'h00, 6'h00, 16'hA5A5, 16'h0000, 16'hA5A5, 5'd12, 5'h1F});
    tbl.push_back('{4'd7, 5'h01, 6'h00, 16'hA5A5, 16'h5A5A, 16'h0000, 5'd11, 5'h1F});
    tbl.push_back('{4'd7, 5'h00, 6'h00, 16'hFFFF, 16'h8000, 16'h7FFF, 5'd17, 5'h1F});
    tbl.push_back('{4'd7, 5'h00, 6'h00, 16'h0001, 16'h7FFF, 16'h8000, 5'd20, 5'h1F});
    tbl.push_back('{4'd8, 5'h01, 6'h00, 16'h00A4, 16'h0000, 16'hFF5B, 5'h01, 5'h01});
    tbl.push_back('{4'd9, 5'h00, 6'h00, 16'hFF8E, 16'h0190, 16'hFFFD, 5'h00, 5'h10});
    tbl.push_back('{4'd10, 5'h00, 6'h00, 16'hFF8E, 16'h0190, 16'h003A, 5'h00, 5'h10});
    tbl.push_back('{4'd9, 5'h00, 6'h00, 16'h0000, 16'h1234, 16'hFFFF, 5'h10, 5'h10});
    tbl.push_back('{4'd10, 5'h00, 6'h00, 16'h0000, 16'h1234, 16'h1234, 5'h10, 5'h10});
    tbl.push_back('{4'd11, 5'h00, 6'h00, 16'hF412, 16'hF412, 16'h5144, 5'h00, 5'h00});
    tbl.push_back('{4'd12, 5'h00, 6'h00, 16'hF412, 16'hF412, 16'h008E, 5'h00, 5'h00});
    tbl.push_back('{4'd11, 5'h00, 6'h00, 16'hFFFF, 16'h040F, 16'hFBF1, 5'h00, 5'h00});
    tbl.push_back('{4'd12, 5'h00, 6'h00, 16'hFFFF, 16'h040F, 16'hFFFF, 5'h00, 5'h00});
    tbl.push_back('{4'd13, 5'h1F, 6'h15, 16'h5555, 16'h1234, 16'h1234, 5'h1F, 5'h1F});
    tbl.push_back('{4'd15, 5'h0A, 6'h00, 16'h0000, 16'h0000, 16'h0000, 5'h0A, 5'h1F});

    // Reset phase: MOVE 1234 presented while Reset is high.
    drive(4'd0, 5'h00, 6'h00, 16'h1234, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef ALU_OUTPUT_REG_EN
    chk("reset_dest", out_d, 16'h0000);
    chk_f("reset", out_f, 5'h00, 5'h1F);
`else
    chk("reset_ignored_dest", out_d, 16'h1234);
    chk_f("reset_ignored", out_f, 5'h00, 5'h1F);
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].op, tbl[k].fin, tbl[k].imm,
            tbl[k].src, tbl[k].dst);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_op%0d", k, tbl[k].op),
          out_d, tbl[k].res);
      if (tbl[k].mask != 5'h00)
        chk_f($sformatf("vec%0d_op%0d", k, tbl[k].op),
              out_f, tbl[k].fl, tbl[k].mask);
    end

    for (int n = 0; n < 2000; n++) begin
      logic [3:0]  ro;
      logic [4:0]  rf;
      logic [5:0]  ri;
      logic [15:0] rs, rd;
      ro = 4'($urandom_range(0, 15));
      rf = 5'($urandom);
      ri = 6'($urandom);
      rs = 16'($urandom);
      rd = 16'($urandom);
      case ($urandom_range(0, 9))
        0: rs = 16'h0000;
        1: rs = 16'hFFFF;
        2: rd = 16'h8000;
        3: rd = 16'h7FFF;
        default: ;
      endcase
      @(negedge clk);
      drive(ro, rf, ri, rs, rd);
      @(posedge clk); #1;
      model(ro, rf, ri, rs, rd, er, ef);
      chk($sformatf("rand%0d_op%0d", n, ro), out_d, er);
      chk_f($sformatf("rand%0d_op%0d", n, ro), out_f, ef, 5'h1F);
    end

    // Back-to-back ADC then MUL: checks output timing.
    @(negedge clk);
    drive(4'd7, 5'h00, 6'h00, 16'h0001, 16'h7FFF);
    model(4'd7, 5'h00, 6'h00, 16'h0001, 16'h7FFF, er, ef);
    @(posedge clk); #1;
    chk("seq_adc", out_d, er);
    @(negedge clk);
    drive(4'd11, 5'h00, 6'h00, 16'hF412, 16'hF412);
    model(4'd11, 5'h00, 6'h00, 16'hF412, 16'hF412, er2, ef2);
    #1;
`ifdef ALU_OUTPUT_REG_EN
    chk("seq_hold_prev", out_d, er);
    chk_f("seq_hold_prev", out_f, ef, 5'h1F);
`else
    chk("seq_zero_latency", out_d, er2);
    chk_f("seq_zero_latency", out_f, ef2, 5'h1F);
`endif
    @(posedge clk); #1;
    chk("seq_mul", out_d, er2);
    chk_f("seq_mul", out_f, ef2, 5'h1F);

    // Reset asserted while a new operation is in flight.
    @(negedge clk);
    drive(4'd7, 5'h01, 6'h00, 16'hFFFF, 16'h8000);
    model(4'd7, 5'h01, 6'h00, 16'hFFFF, 16'h8000, er, ef);
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef ALU_OUTPUT_REG_EN
    chk("midreset_dest", out_d, 16'h0000);
    chk_f("midreset", out_f, 5'h00, 5'h1F);
`else
    chk("midreset_dest", out_d, er);
    chk_f("midreset", out_f, ef, 5'h1F);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_dest", out_d, er);
    chk_f("after_reset", out_f, ef, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
